// File: rtl/tpg_pkg.sv
// Shared definitions for the burst test-pattern generator: pattern modes,
// FSM states, seed words and the per-width Galois LFSR taps.
package tpg_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT = 2'd0,
        MODE_LFSR  = 2'd1,
        MODE_WALK1 = 2'd2,
        MODE_ALT   = 2'd3
    } tpg_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tpg_state_e;

    // Seeds are kept at full 64-bit width and truncated to DATA_W where used.
    localparam logic [63:0] SEED_COUNT = 64'h0000_0000_0000_0000;
    localparam logic [63:0] SEED_LFSR  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] SEED_WALK1 = 64'h0000_0000_0000_0001;
    localparam logic [63:0] SEED_ALT   = 64'hAAAA_AAAA_AAAA_AAAA;

    function automatic logic [63:0] lfsr_taps(input int width);
        case (width)
            8:       return 64'h0000_0000_0000_00B8;
            16:      return 64'h0000_0000_0000_B400;
            64:      return 64'hD800_0000_0000_0000;
            default: return 64'h0000_0000_8020_0003;
        endcase
    endfunction

endpackage

// File: rtl/tpg_pattern_core.sv
// Pattern register for the burst generator: reloads the mode seed when a burst
// starts in a different mode than the previous one, and steps on each accept.
module tpg_pattern_core
    import tpg_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              load_in,
    input  logic              advance_in,
    input  tpg_mode_e         mode_in,
    output logic [DATA_W-1:0] data_out
);

    localparam logic [63:0]       TAPS_FULL  = lfsr_taps(DATA_W);
    localparam logic [DATA_W-1:0] TAPS       = TAPS_FULL[DATA_W-1:0];
    localparam logic [DATA_W-1:0] SEED_CNT_W = SEED_COUNT[DATA_W-1:0];
    localparam logic [DATA_W-1:0] SEED_LFS_W = SEED_LFSR[DATA_W-1:0];
    localparam logic [DATA_W-1:0] SEED_WLK_W = SEED_WALK1[DATA_W-1:0];
    localparam logic [DATA_W-1:0] SEED_ALT_W = SEED_ALT[DATA_W-1:0];

    logic [DATA_W-1:0] pat_q, pat_d;
    logic [DATA_W-1:0] seed;
    tpg_mode_e         mode_q, mode_d;

    always_comb begin
        seed = SEED_CNT_W;
        case (mode_in)
            MODE_COUNT: seed = SEED_CNT_W;
            MODE_LFSR:  seed = SEED_LFS_W;
            MODE_WALK1: seed = SEED_WLK_W;
            MODE_ALT:   seed = SEED_ALT_W;
            default:    seed = SEED_CNT_W;
        endcase
    end

    // mode_q is both the latched mode of the running burst and the
    // "previous mode" compared against at the next burst start.
    always_comb begin
        pat_d  = pat_q;
        mode_d = mode_q;
        if (load_in) begin
            mode_d = mode_in;
            if (mode_in != mode_q) begin
                pat_d = seed;
            end
        end else if (advance_in) begin
            case (mode_q)
                MODE_COUNT: pat_d = pat_q + DATA_W'(1);
                MODE_LFSR:  pat_d = (pat_q >> 1) ^ (pat_q[0] ? TAPS : '0);
                MODE_WALK1: pat_d = {pat_q[DATA_W-2:0], pat_q[DATA_W-1]};
                MODE_ALT:   pat_d = ~pat_q;
                default:    pat_d = pat_q;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pat_q  <= '0;
            mode_q <= MODE_COUNT;
        end else begin
            pat_q  <= pat_d;
            mode_q <= mode_d;
        end
    end

    assign data_out = pat_q;

endmodule

// File: rtl/tpg_burst_gen.sv
// Triggered burst / continuous test-pattern source with valid/ready output,
// beat counter, sticky stop request and a one-cycle done pulse.
module tpg_burst_gen
    import tpg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              trigger_in,
    input  logic [1:0]        mode_in,
    input  logic [LEN_W-1:0]  burst_len_in,
    input  logic              stop_in,
    input  logic              ready_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              busy_out,
    output logic              done_out
);

    tpg_state_e        state_q, state_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic              stop_q, stop_d;
    logic              done_q, done_d;
    logic              load;
    logic              accept;
    logic              last_beat;

    // A count of zero means continuous: it is never decremented and never
    // matches the final-beat value of one.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        stop_d    = stop_q;
        done_d    = 1'b0;
        load      = 1'b0;
        accept    = (state_q == ST_RUN) && ready_in;
        last_beat = (count_q == LEN_W'(1)) || stop_in || stop_q;
        case (state_q)
            ST_IDLE: begin
                if (trigger_in) begin
                    state_d = ST_RUN;
                    load    = 1'b1;
                    count_d = burst_len_in;
                    stop_d  = 1'b0;
                end
            end
            ST_RUN: begin
                if (accept && last_beat) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    stop_d  = 1'b0;
                end else begin
                    if (accept && (count_q != '0)) begin
                        count_d = count_q - LEN_W'(1);
                    end
                    if (stop_in) begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            stop_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            stop_q  <= stop_d;
            done_q  <= done_d;
        end
    end

    tpg_pattern_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .load_in    (load),
        .advance_in (accept),
        .mode_in    (tpg_mode_e'(mode_in)),
        .data_out   (data_out)
    );

    assign valid_out = (state_q == ST_RUN);
    assign busy_out  = (state_q == ST_RUN);
    assign done_out  = done_q;

endmodule

// File: tb/tb_tpg_burst_gen.sv
// Directed bench for tpg_burst_gen: a 32-bit instance (a) and an 8-bit
// instance (b) share clock, reset and pattern controls but have own triggers.
module tb_tpg_burst_gen;

    logic        clk;
    logic        rst;
    logic        trig_a;
    logic        trig_b;
    logic [1:0]  mode;
    logic [15:0] len;
    logic        stop;
    logic        ready;

    logic [31:0] data_a;
    logic        valid_a, busy_a, done_a;
    logic [7:0]  data_b;
    logic        valid_b, busy_b, done_b;

    int checks = 0;
    int errors = 0;

    tpg_burst_gen #(.DATA_W(32), .LEN_W(16)) dut_a (
        .clk_in       (clk),
        .rst_in       (rst),
        .trigger_in   (trig_a),
        .mode_in      (mode),
        .burst_len_in (len),
        .stop_in      (stop),
        .ready_in     (ready),
        .data_out     (data_a),
        .valid_out    (valid_a),
        .busy_out     (busy_a),
        .done_out     (done_a)
    );

    tpg_burst_gen #(.DATA_W(8), .LEN_W(16)) dut_b (
        .clk_in       (clk),
        .rst_in       (rst),
        .trigger_in   (trig_b),
        .mode_in      (mode),
        .burst_len_in (len),
        .stop_in      (stop),
        .ready_in     (ready),
        .data_out     (data_b),
        .valid_out    (valid_b),
        .busy_out     (busy_b),
        .done_out     (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are driven while the clock is low; outputs are sampled at the
    // following falling edge, i.e. the state after the rising edge.
    task automatic applyStimulus(input logic ta, input logic tb, input logic stp,
                                 input logic rdy, input logic rs);
        trig_a = ta;
        trig_b = tb;
        stop   = stp;
        ready  = rdy;
        rst    = rs;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkA(input string tag, input logic v, input logic b,
                          input logic d, input logic [31:0] dat);
        checkOutput({tag, ".valid"}, 64'(valid_a), 64'(v));
        checkOutput({tag, ".busy"},  64'(busy_a),  64'(b));
        checkOutput({tag, ".done"},  64'(done_a),  64'(d));
        checkOutput({tag, ".data"},  64'(data_a),  64'(dat));
    endtask

    task automatic checkB(input string tag, input logic v, input logic b,
                          input logic d, input logic [7:0] dat);
        checkOutput({tag, ".valid"}, 64'(valid_b), 64'(v));
        checkOutput({tag, ".busy"},  64'(busy_b),  64'(b));
        checkOutput({tag, ".done"},  64'(done_b),  64'(d));
        checkOutput({tag, ".data"},  64'(data_b),  64'(dat));
    endtask

    initial begin
        trig_a = 1'b0;
        trig_b = 1'b0;
        mode   = 2'd0;
        len    = 16'd0;
        stop   = 1'b0;
        ready  = 1'b0;
        rst    = 1'b1;

        $display("[TB] reset");
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);
        checkA("rst_a", 0, 0, 0, 32'h0);
        checkB("rst_b", 0, 0, 0, 8'h0);
        applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] COUNT len 4, twice");
        mode = 2'd0;
        len  = 16'd4;
        applyStimulus(1, 0, 0, 1, 0);
        checkA("cnt1.b0", 1, 1, 0, 32'd0);
        applyStimulus(0, 0, 0, 1, 0);
        checkA("cnt1.b1", 1, 1, 0, 32'd1);
        applyStimulus(0, 0, 0, 1, 0);
        checkA("cnt1.b2", 1, 1, 0, 32'd2);
        applyStimulus(0, 0, 0, 1, 0);
        checkA("cnt1.b3", 1, 1, 0, 32'd3);
        applyStimulus(0, 0, 0, 1, 0);
        checkA("cnt1.end", 0, 0, 1, 32'd4);
        applyStimulus(1, 0, 0, 1, 0);
        checkA("cnt2.b0", 1, 1, 0, 32'd4);
        applyStimulus(0, 0, 0, 1, 0);
        checkA("cnt2.b1", 1, 1, 0, 32'd5);
        applyStimulus(0, 0, 0, 1, 0);
        checkA("cnt2.b2", 1, 1, 0, 32'd6);
        applyStimulus(0, 0, 0, 1, 0);
        checkA("cnt2.b3", 1, 1, 0, 32'd7);
        applyStimulus(0, 0, 0, 1, 0);
        checkA("cnt2.end", 0, 0, 1, 32'd8);
        applyStimulus(0, 0, 0, 0, 0);
        checkA("cnt2.idle", 0, 0, 0, 32'd8);

        $display("[TB] LFSR len 3 with back-pressure");
        mode = 2'd1;
        len  = 16'd3;
        applyStimulus(1, 0, 0, 1, 0);
        checkA("lfsr.b0", 1, 1, 0, 32'hFFFF_FFFF);
        applyStimulus(0, 0, 0, 1, 0);
        checkA("lfsr.b1", 1, 1, 0, 32'hFFDF_FFFC);
        applyStimulus(0, 0, 0, 0, 0);
        checkA("lfsr.hold1", 1, 1, 0, 32'hFFDF_FFFC);
        applyStimulus(0, 0, 0, 0, 0);
        checkA("lfsr.hold2", 1, 1, 0, 32'hFFDF_FFFC);
        applyStimulus(0, 0, 0, 0, 0);
        checkA("lfsr.hold3", 1, 1, 0, 32'hFFDF_FFFC);
        applyStimulus(0, 0, 0, 1, 0);
        checkA("lfsr.b2", 1, 1, 0, 32'h7FEF_FFFE);
        applyStimulus(0, 0, 0, 1, 0);
        checkA("lfsr.end", 0, 0, 1, 32'h3FF7_FFFF);
        applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] 8-bit COUNT continuous across wrap, sticky stop");
        mode = 2'd0;
        len  = 16'd0;
        applyStimulus(0, 1, 0, 1, 0);
        for (int i = 0; i < 254; i++) begin
            checkOutput("wrap.run", 64'(data_b), 64'(i));
            applyStimulus(0, 0, 0, 1, 0);
        end
        checkB("wrap.fe", 1, 1, 0, 8'hFE);
        applyStimulus(0, 0, 0, 1, 0);
        checkB("wrap.ff", 1, 1, 0, 8'hFF);
        applyStimulus(0, 0, 0, 1, 0);
        checkB("wrap.00", 1, 1, 0, 8'h00);
        applyStimulus(0, 0, 1, 0, 0);
        checkB("wrap.stopheld", 1, 1, 0, 8'h00);
        applyStimulus(0, 0, 0, 1, 0);
        checkB("wrap.end", 0, 0, 1, 8'h01);
        applyStimulus(0, 0, 0, 0, 0);
        checkB("wrap.idle", 0, 0, 0, 8'h01);

        $display("[TB] 8-bit WALK1 len 5, mid-burst trigger and mode change");
        mode = 2'd2;
        len  = 16'd5;
        applyStimulus(0, 1, 0, 1, 0);
        checkB("walk.b0", 1, 1, 0, 8'h01);
        applyStimulus(0, 0, 0, 1, 0);
        checkB("walk.b1", 1, 1, 0, 8'h02);
        mode = 2'd3;
        len  = 16'd1;
        applyStimulus(0, 1, 0, 1, 0);
        checkB("walk.b2", 1, 1, 0, 8'h04);
        applyStimulus(0, 1, 0, 1, 0);
        checkB("walk.b3", 1, 1, 0, 8'h08);
        applyStimulus(0, 0, 0, 1, 0);
        checkB("walk.b4", 1, 1, 0, 8'h10);
        applyStimulus(0, 0, 0, 1, 0);
        checkB("walk.end", 0, 0, 1, 8'h20);
        applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] reset mid-burst");
        mode = 2'd0;
        len  = 16'd8;
        applyStimulus(1, 0, 0, 1, 0);
        checkA("mid.b0", 1, 1, 0, 32'd0);
        applyStimulus(0, 0, 0, 1, 0);
        checkA("mid.b1", 1, 1, 0, 32'd1);
        applyStimulus(0, 0, 0, 1, 0);
        checkA("mid.b2", 1, 1, 0, 32'd2);
        applyStimulus(0, 0, 0, 0, 1);
        checkA("mid.rst", 0, 0, 0, 32'd0);
        applyStimulus(1, 0, 0, 1, 0);
        checkA("mid.restart", 1, 1, 0, 32'd0);
        applyStimulus(0, 0, 1, 1, 0);
        checkA("mid.stopend", 0, 0, 1, 32'd1);
        applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] ALT len 2, stop on last beat");
        mode = 2'd3;
        len  = 16'd2;
        applyStimulus(1, 0, 0, 1, 0);
        checkA("alt.b0", 1, 1, 0, 32'hAAAA_AAAA);
        applyStimulus(0, 0, 0, 1, 0);
        checkA("alt.b1", 1, 1, 0, 32'h5555_5555);
        applyStimulus(0, 0, 1, 1, 0);
        checkA("alt.end", 0, 0, 1, 32'hAAAA_AAAA);
        applyStimulus(0, 0, 0, 0, 0);
        checkA("alt.single", 0, 0, 0, 32'hAAAA_AAAA);
        applyStimulus(0, 0, 0, 0, 0);
        checkA("alt.idle", 0, 0, 0, 32'hAAAA_AAAA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tpg_burst_gen.md
# tpg_burst_gen

Parametrised transmission test-pattern generator feeding the master FIFO / link datapath during bring-up and throughput tests. On a trigger it emits a burst of N words, or a continuous stream, in one of four selectable patterns over a valid/ready handshake with full back-pressure support. It is the next-generation replacement for the single-word free-running counter source.

## Interface
Parameters:
- DATA_W, 32, word width; legal values 8, 16, 32, 64.
- LEN_W, 16, burst-length counter width.

Ports (one clock; reset is synchronous and active-high):
- clk_in  in  1  clock
- rst_in  in  1  synchronous, active-high reset
- trigger_in  in  1  start burst; sampled only in IDLE
- mode_in  in  2  pattern: 0 COUNT, 1 LFSR, 2 WALK1, 3 ALT; latched at burst start
- burst_len_in  in  LEN_W  beats per burst; 0 = continuous; latched at burst start
- stop_in  in  1  end a burst (continuous or finite) at the next beat boundary
- ready_in  in  1  sink accepts the word on data_out
- data_out  out  DATA_W  pattern word
- valid_out  out  1  data_out valid
- busy_out  out  1  FSM in RUN
- done_out  out  1  one-cycle pulse after the final beat is accepted

## Operation
- FSM states:
  - IDLE: trigger_in=1 → RUN. Latch mode and length. Load the beat counter with burst_len_in.
  - RUN: a beat is accepted when valid_out && ready_in.
    - Finite burst: the accept with remaining==1 → IDLE.
    - Stop: stop_in seen (registered sticky flag) → IDLE at the next accept.
- Patterns. data_out = current pattern register; the register advances only on accept.
  - COUNT: reset 0; +1 modulo 2^DATA_W; all-ones wraps to 0.
  - LFSR: Galois, reset/seed all-ones; next = (s>>1) ^ (s[0] ? TAPS : 0).
    - TAPS for 32 = 0x80200003; 8 = 0xB8; 16 = 0xB400; 64 = 0xD800000000000000.
  - WALK1: seed 1; rotate left by 1.
  - ALT: seed 0xAA..A; bitwise invert each beat.
- Persistence:
  - Pattern register continues across bursts when the latched mode equals the previous burst's mode.
  - On a mode change it reloads the new mode's seed at burst start.
- Handshake: while valid_out && !ready_in, data_out and valid_out hold stable. valid_out never drops without an accept.
- trigger_in in RUN is ignored; mode_in and burst_len_in changes in RUN are ignored.
- stop_in in IDLE is ignored. stop_in coincident with the last finite beat gives a single done pulse.
- Reset (including mid-burst): state IDLE; all outputs 0; pattern register 0; previous mode COUNT; stop flag cleared.

## Timing
- Reset values: data_out 0, valid_out 0, busy_out 0, done_out 0.
- Start: trigger_in high in cycle T (IDLE) → busy_out and valid_out high from T+1, with the first word on data_out at T+1.
- Throughput: ready_in held high gives one word per cycle, with no bubbles between beats.
- Termination: final accept in cycle A → at A+1, valid_out=0, busy_out=0, done_out=1 (one cycle). A trigger_in at A+1 starts a new burst, so valid_out returns at A+2.
- Stop: stop_in at cycle S → the accept at the first cycle ≥S ends the burst; same A+1 rules apply.

## Structure
- Package tpg_pkg holds:
  - mode encoding (localparams / enum: MODE_COUNT, MODE_LFSR, MODE_WALK1, MODE_ALT);
  - per-width LFSR tap constant function;
  - seed constants.
- Sub-module tpg_pattern_core:
  - holds the pattern register, the seed load (on mode change), and the advance logic for all modes;
  - inputs: load, advance, mode.
- Top level: FSM, beat counter, stop flag, output registers.

## Test plan
- Reset, then mode 0, len 4, ready=1 → data 0,1,2,3 on four consecutive cycles; done at the cycle after the last beat. A second identical burst gives 4,5,6,7.
- Mode 1, len 3, DATA_W=32 → 0xFFFFFFFF, 0xFFDFFFFC, then the next Galois step; data held stable across 3 cycles of ready=0 inserted after beat 1.
- Mode 0, len 0 (continuous), pattern preset near wrap → 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000. stop_in held for one cycle → exactly one more beat accepted, then done pulse.
- Mode 2, len 5, DATA_W=8 → 0x01, 0x02, 0x04, 0x08, 0x10. trigger_in and mode_in toggled mid-burst → no effect.
- rst_in asserted mid-burst (beat 2 of 8, ready=0) → next cycle all outputs 0, IDLE. A new COUNT trigger then emits 0 first.
- Mode 3, len 2, stop_in and the last accept in the same cycle → 0xAAAAAAAA, 0x55555555, single done pulse.
